// File: rtl/piece_generator.sv
// Piece generator: a 7-bag randomiser driven by a 16-bit Fibonacci LFSR.
// It holds a current piece (shape_id) and a preview piece (next_id). A
// consumer strobes req while valid is high to take the current piece. The
// preview piece is then promoted, and a new preview piece is drawn.
//
// Handshake: valid is high exactly while both pieces are populated. A req
// sampled on a rising edge with valid=1 consumes shape_id. A req while
// valid=0 has no effect. seed_en wins over req in the same cycle.
module piece_generator #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_en,
  input  logic [15:0] seed,
  input  logic        req,
  output logic [2:0]  shape_id,
  output logic [2:0]  next_id,
  output logic        valid
);

  typedef enum logic [1:0] {
    FILL_CUR  = 2'd0,
    FILL_NEXT = 2'd1,
    READY     = 2'd2
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] RESET_LFSR = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [6:0]  mask, mask_nxt;
  logic [2:0]  rej_cnt, rej_nxt;
  logic [2:0]  shape_nxt, next_nxt;

  logic        fb;
  logic [2:0]  cand;
  logic [7:0]  used8;
  logic        cand_ok;
  logic        forced;
  logic        accept;
  logic [2:0]  lowest_free;
  logic [2:0]  drawn;
  logic [6:0]  mask_set;
  logic [6:0]  mask_after;

  // Draw datapath: candidate from the pre-shift LFSR, bag filtering, and the
  // forced fallback after seven consecutive rejects.
  always_comb begin
    fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    cand = lfsr[2:0];
    // Code 7 is treated as permanently used, so it is always rejected.
    used8 = {1'b1, mask};
    cand_ok = ~used8[cand];
    forced = (rej_cnt == 3'd7);
    accept = forced | cand_ok;
    lowest_free = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (!mask[i]) lowest_free = 3'(i);
    end
    drawn = forced ? lowest_free : cand;
    mask_set = mask | (7'b0000001 << drawn);
    // A full bag empties in the same cycle, which starts the next permutation.
    mask_after = (mask_set == 7'h7F) ? 7'h00 : mask_set;
    lfsr_nxt = seed_en ? ((seed == 16'h0000) ? 16'h0001 : seed)
                       : {lfsr[14:0], fb};
  end

  // Next-state logic: fill current, then preview, then wait for a consume.
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    rej_nxt   = rej_cnt;
    shape_nxt = shape_id;
    next_nxt  = next_id;
    if (seed_en) begin
      state_nxt = FILL_CUR;
      mask_nxt  = 7'h00;
      rej_nxt   = 3'd0;
    end else begin
      case (state)
        FILL_CUR: begin
          if (accept) begin
            shape_nxt = drawn;
            mask_nxt  = mask_after;
            rej_nxt   = 3'd0;
            state_nxt = FILL_NEXT;
          end else begin
            rej_nxt = rej_cnt + 3'd1;
          end
        end
        FILL_NEXT: begin
          if (accept) begin
            next_nxt  = drawn;
            mask_nxt  = mask_after;
            rej_nxt   = 3'd0;
            state_nxt = READY;
          end else begin
            rej_nxt = rej_cnt + 3'd1;
          end
        end
        READY: begin
          if (req) begin
            shape_nxt = next_id;
            state_nxt = FILL_NEXT;
          end
        end
        default: state_nxt = FILL_CUR;
      endcase
    end
  end

  // State register. valid is registered from the next state so that it
  // tracks READY exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL_CUR;
      lfsr     <= RESET_LFSR;
      mask     <= 7'h00;
      rej_cnt  <= 3'd0;
      shape_id <= 3'd0;
      next_id  <= 3'd0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_nxt;
      mask     <= mask_nxt;
      rej_cnt  <= rej_nxt;
      shape_id <= shape_nxt;
      next_id  <= next_nxt;
      valid    <= (state_nxt == READY);
    end
  end

endmodule

// File: tb/tb_piece_generator.sv
// Bench for piece_generator: directed scenarios plus randomized traffic,
// compared every cycle against a piece-count model of the 7-bag generator.
module tb_piece_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_en = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        req = 1'b0;
  logic [2:0]  shape_id;
  logic [2:0]  next_id;
  logic        valid;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] SEED_EFF = 16'hACE1;

  piece_generator dut (
    .clk      (clk),
    .rst      (rst),
    .seed_en  (seed_en),
    .seed     (seed),
    .req      (req),
    .shape_id (shape_id),
    .next_id  (next_id),
    .valid    (valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pieces held (0, 1 or 2), the bag as a set of used codes, and the reject
  // streak. The LFSR is part of the observable behaviour and is modelled
  // directly from its polynomial.
  logic [15:0] m_lfsr;
  bit          m_used[7];
  int          m_rej;
  int          m_have;
  logic [2:0]  m_cur, m_nxt;

  logic [6:0] exp_q[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED_EFF;
    foreach (m_used[i]) m_used[i] = 1'b0;
    m_rej  = 0;
    m_have = 0;
    m_cur  = 3'd0;
    m_nxt  = 3'd0;
  endtask

  task automatic model_step(input bit se, input logic [15:0] sd, input bit rq);
    logic [15:0] l;
    int pick;
    int n_used;
    if (se) begin
      m_lfsr = (sd == 16'h0000) ? 16'h0001 : sd;
      foreach (m_used[i]) m_used[i] = 1'b0;
      m_rej  = 0;
      m_have = 0;
      return;
    end
    l = m_lfsr;
    if (m_have < 2) begin
      pick = -1;
      if (m_rej == 7) begin
        for (int i = 0; i < 7; i++) if (!m_used[i] && pick < 0) pick = i;
      end else if (int'(l[2:0]) < 7 && !m_used[l[2:0]]) begin
        pick = int'(l[2:0]);
      end
      if (pick < 0) begin
        m_rej++;
      end else begin
        m_used[pick] = 1'b1;
        n_used = 0;
        foreach (m_used[i]) n_used += int'(m_used[i]);
        if (n_used == 7) foreach (m_used[i]) m_used[i] = 1'b0;
        m_rej = 0;
        if (m_have == 0) m_cur = 3'(pick);
        else             m_nxt = 3'(pick);
        m_have++;
      end
    end else if (rq) begin
      m_cur  = m_nxt;
      m_have = 1;
    end
    m_lfsr = lfsr_step(l);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 16'd0, 16'd1);
      return;
    end
    e = exp_q.pop_front();
    check("shape_id", {13'd0, shape_id}, {13'd0, e[2:0]});
    check("next_id",  {13'd0, next_id},  {13'd0, e[5:3]});
    check("valid",    {15'd0, valid},    {15'd0, e[6]});
    check("no_code7", {15'd0, (shape_id == 3'd7) || (next_id == 3'd7)}, 16'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives inputs, steps the model at the rising
  // edge and compares at the next falling edge.
  task automatic cycle(input bit se, input logic [15:0] sd, input bit rq);
    seed_en = se;
    seed    = sd;
    req     = rq;
    @(posedge clk);
    model_step(se, sd, rq);
    exp_q.push_back({(m_have == 2), m_nxt, m_cur});
    @(negedge clk);
    compare_outputs();
    seed_en = 1'b0;
    req     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check("rst_shape", {13'd0, shape_id}, 16'd0);
    check("rst_next",  {13'd0, next_id},  16'd0);
    check("rst_valid", {15'd0, valid},    16'd0);
    check("rst_lfsr",  dut.lfsr,          SEED_EFF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_valid_latency(input string tag);
    int n;
    n = 0;
    while (!valid && n < 20) begin
      cycle(1'b0, 16'h0, 1'b0);
      n++;
    end
    check(tag, {15'd0, (n >= 2 && n <= 16)}, 16'd1);
  endtask

  function automatic logic [15:0] find_reject_seed();
    logic [15:0] l;
    bit ok;
    for (int s = 1; s < 65536; s++) begin
      l  = 16'(s);
      ok = 1'b1;
      for (int k = 0; k < 7; k++) begin
        if (l[2:0] != 3'd7) ok = 1'b0;
        l = lfsr_step(l);
      end
      if (ok) return 16'(s);
    end
    return 16'h0000;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  got_pieces[14];
    logic [6:0]  bag;
    logic [15:0] rs;
    logic [2:0]  held;
    int          n_got, budget, rises;
    bit          prev_v;

    // Reset at time zero.
    #1;
    model_reset();
    check("init_shape", {13'd0, shape_id}, 16'd0);
    check("init_next",  {13'd0, next_id},  16'd0);
    check("init_valid", {15'd0, valid},    16'd0);
    @(negedge clk);
    rst = 1'b0;
    check_valid_latency("valid_latency_reset");

    // Zero seed: LFSR loads 1, pieces 1 then 2, then consume.
    cycle(1'b1, 16'h0000, 1'b0);
    check("zs_lfsr", dut.lfsr, 16'h0001);
    check("zs_valid0", {15'd0, valid}, 16'd0);
    cycle(1'b0, 16'h0, 1'b0);
    check("zs_shape1", {13'd0, shape_id}, 16'd1);
    cycle(1'b0, 16'h0, 1'b0);
    check("zs_next2", {13'd0, next_id}, 16'd2);
    check("zs_valid1", {15'd0, valid}, 16'd1);
    cycle(1'b0, 16'h0, 1'b1);
    check("zs_valid_drop", {15'd0, valid}, 16'd0);
    check("zs_lfsr8", dut.lfsr, 16'h0008);
    check("zs_shape_shift", {13'd0, shape_id}, 16'd2);
    cycle(1'b0, 16'h0, 1'b0);
    check("zs_valid_again", {15'd0, valid}, 16'd1);
    check("zs_shape2", {13'd0, shape_id}, 16'd2);
    check("zs_next0", {13'd0, next_id}, 16'd0);

    // Seven rejects in a row: the eighth draw takes the lowest free code (0).
    rs = find_reject_seed();
    check("reject_seed_found", {15'd0, (rs != 16'h0000)}, 16'd1);
    cycle(1'b1, rs, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 16'h0, 1'b0);
      check("rej_hold_shape", {13'd0, shape_id}, 16'd2);
    end
    cycle(1'b0, 16'h0, 1'b0);
    check("rej_forced_pick", {13'd0, shape_id}, 16'd0);

    // 14 consumptions after a reseed form two permutations of 0..6.
    cycle(1'b1, 16'(($urandom_range(1, 65535))), 1'b0);
    n_got  = 0;
    budget = 0;
    while (n_got < 14 && budget < 400) begin
      if (valid) begin
        got_pieces[n_got] = shape_id;
        n_got++;
        cycle(1'b0, 16'h0, 1'b1);
      end else begin
        cycle(1'b0, 16'h0, 1'b0);
      end
      budget++;
    end
    check("perm_collected", 16'(n_got), 16'd14);
    for (int g = 0; g < 2; g++) begin
      bag = 7'h00;
      for (int k = 0; k < 7; k++) begin
        if (got_pieces[g*7+k] != 3'd7) bag[got_pieces[g*7+k]] = 1'b1;
      end
      check("perm_bag", {9'd0, bag}, 16'h007F);
    end

    // Reset while filling the preview piece.
    cycle(1'b1, 16'h1234, 1'b0);
    budget = 0;
    while (m_have != 1 && budget < 20) begin
      cycle(1'b0, 16'h0, 1'b0);
      budget++;
    end
    check("reach_fill_next", {15'd0, (m_have == 1)}, 16'd1);
    do_reset();
    check_valid_latency("valid_latency_midfill");

    // seed_en and req together in READY: reseed wins, no promotion.
    held = shape_id;
    cycle(1'b1, 16'h5A5A, 1'b1);
    check("se_req_valid", {15'd0, valid}, 16'd0);
    check("se_req_shape", {13'd0, shape_id}, {13'd0, held});

    // req held high: valid never high on two consecutive cycles.
    prev_v = 1'b0;
    rises  = 0;
    for (int k = 0; k < 200; k++) begin
      cycle(1'b0, 16'h0, 1'b1);
      check("valid_not_twice", {15'd0, (prev_v && valid)}, 16'd0);
      if (valid && !prev_v) rises++;
      prev_v = valid;
    end
    check("req_held_progress", {15'd0, (rises >= 10)}, 16'd1);

    // Randomized traffic with occasional reseeds and resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 63) == 0) begin
        rs = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
        cycle(1'b1, rs, 1'($urandom_range(0, 1)));
      end else begin
        cycle(1'b0, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
